sdr_tx_packetizer: RTL and testbench

//  Collects parallel multi-channel I/Q samples into a sample FIFO and frames them as Ethernet packets.

---
 rtl/sdr_pkt_pkg.sv | 23 ++
 rtl/sdr_sample_fifo.sv | 53 +++++
 rtl/sdr_tx_packetizer.sv | 214 +++++++++++++++++++++
 tb/tb_sdr_tx_packetizer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkt_pkg.sv
// Shared types and helpers for the SDR transmit packetizer.
package sdr_pkt_pkg;

  localparam int unsigned HDR_WORDS   = 5;
  localparam int unsigned W4_DROP_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } tx_state_e;

  // Sign-extend the low w bits of x to 16 bits.
  function automatic logic [15:0] sext16(input logic [15:0] x, input int unsigned w);
    logic [15:0] r;
    r = x;
    for (int b = 0; b < 16; b++) begin
      if (b >= int'(w)) r[b] = x[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/sdr_sample_fifo.sv
// Synchronous sample-vector FIFO with flush; exposes head and head+1 for gapless reads.
module sdr_sample_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [WIDTH-1:0]         o_rdata_nxt,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  assign o_rdata     = r_mem[r_rd_ptr];
  assign o_rdata_nxt = r_mem[r_rd_ptr + AW'(1)];
  assign o_full      = (r_level == LW'(DEPTH));
  assign o_empty     = (r_level == '0);
  assign o_level     = r_level;

endmodule

// File: rtl/sdr_tx_packetizer.sv
// Frames buffered multi-channel I/Q sample vectors as Ethernet packets on the MAC ff_tx stream.
module sdr_tx_packetizer
  import sdr_pkt_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned SAMPLE_W        = 12,
  parameter int unsigned SAMPLES_PER_PKT = 64,
  parameter int unsigned FIFO_DEPTH      = 256,
  parameter logic [47:0] DST_MAC         = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC         = 48'h020000000001,
  parameter logic [15:0] ETHERTYPE       = 16'h88B5
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           enable,
  input  logic                           sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]     sample_i,
  input  logic [NUM_CH*SAMPLE_W-1:0]     sample_q,
  input  logic                           ff_tx_rdy,
  output logic [31:0]                    ff_tx_data,
  output logic                           ff_tx_wren,
  output logic                           ff_tx_sop,
  output logic                           ff_tx_eop,
  output logic [1:0]                     ff_tx_mod,
  output logic                           ff_tx_err,
  output logic                           ff_tx_crc_fwd,
  output logic [15:0]                    overflow_cnt,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           busy
);

  localparam int unsigned DW    = 2 * NUM_CH * SAMPLE_W;
  localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CH_W  = $clog2(NUM_CH + 1);
  localparam int unsigned ENT_W = $clog2(SAMPLES_PER_PKT + 1);
  localparam int unsigned HI_W  = $clog2(HDR_WORDS);

  tx_state_e        r_state;
  logic [31:0]      r_data;
  logic             r_wren, r_sop, r_eop;
  logic [HI_W-1:0]  r_hdr_idx;
  logic [CH_W-1:0]  r_ch;
  logic [ENT_W-1:0] r_ent;
  logic [15:0]      r_seq;
  logic             r_drop, r_pkt_drop;
  logic [15:0]      r_ovf_cnt;

  logic [DW-1:0]    w_head, w_head_nxt;
  logic             w_full, w_empty;
  logic [LW-1:0]    w_level, w_level_nxt;
  logic             w_push, w_drop, w_pop, w_flush, w_xfer, w_start, w_restart, w_drop_clr;
  logic [31:0]      w_word_cur [NUM_CH];
  logic [31:0]      w_word_nxt [NUM_CH];
  logic [31:0]      w_pay_next, w_hdr_next;
  logic [CH_W-1:0]  w_ch_next;
  logic [ENT_W-1:0] w_ent_next;
  logic             w_eop_next;

  assign w_xfer      = r_wren && ff_tx_rdy;
  assign w_push      = sample_valid && enable && !w_full;
  assign w_drop      = sample_valid && enable && w_full;
  assign w_pop       = (r_state == ST_PAYLOAD) && w_xfer && (r_ch == CH_W'(NUM_CH - 1)) && !w_empty;
  assign w_flush     = (r_state == ST_IDLE) && !enable;
  assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);
  assign w_start     = enable && (w_level >= LW'(SAMPLES_PER_PKT));
  // Back-to-back decision must see the level after this cycle's pop/push.
  assign w_restart   = enable && (w_level_nxt >= LW'(SAMPLES_PER_PKT));
  assign w_drop_clr  = (r_state == ST_HDR) && (r_hdr_idx == '0) && w_xfer;

  sdr_sample_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_wdata     ({sample_q, sample_i}),
    .i_pop       (w_pop),
    .o_rdata     (w_head),
    .o_rdata_nxt (w_head_nxt),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_word
    assign w_word_cur[c] = {sext16(16'(w_head[c*SAMPLE_W +: SAMPLE_W]), SAMPLE_W),
                            sext16(16'(w_head[(NUM_CH+c)*SAMPLE_W +: SAMPLE_W]), SAMPLE_W)};
    assign w_word_nxt[c] = {sext16(16'(w_head_nxt[c*SAMPLE_W +: SAMPLE_W]), SAMPLE_W),
                            sext16(16'(w_head_nxt[(NUM_CH+c)*SAMPLE_W +: SAMPLE_W]), SAMPLE_W)};
  end

  // Next payload word: next channel of the head entry, or ch0 of the following entry.
  always_comb begin
    w_pay_next = w_word_nxt[0];
    w_ch_next  = '0;
    w_ent_next = r_ent + ENT_W'(1);
    for (int c = 1; c < NUM_CH; c++) begin
      if (r_ch == CH_W'(c - 1)) begin
        w_pay_next = w_word_cur[c];
        w_ch_next  = CH_W'(c);
        w_ent_next = r_ent;
      end
    end
  end

  assign w_eop_next = (w_ent_next == ENT_W'(SAMPLES_PER_PKT - 1)) && (w_ch_next == CH_W'(NUM_CH - 1));

  always_comb begin
    w_hdr_next = '0;
    case (r_hdr_idx)
      HI_W'(0): w_hdr_next = {DST_MAC[15:0], SRC_MAC[47:32]};
      HI_W'(1): w_hdr_next = SRC_MAC[31:0];
      HI_W'(2): w_hdr_next = {ETHERTYPE, r_seq};
      HI_W'(3): begin
        w_hdr_next = {8'(NUM_CH), 8'h00, 16'(SAMPLES_PER_PKT)};
        w_hdr_next[W4_DROP_BIT] = r_pkt_drop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_wren     <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_hdr_idx  <= '0;
      r_ch       <= '0;
      r_ent      <= '0;
      r_seq      <= '0;
      r_pkt_drop <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_HDR;
            r_wren    <= 1'b1;
            r_sop     <= 1'b1;
            r_eop     <= 1'b0;
            r_hdr_idx <= '0;
            r_data    <= DST_MAC[47:16];
          end
        end
        ST_HDR: begin
          if (w_xfer) begin
            r_sop <= 1'b0;
            if (r_hdr_idx == '0) r_pkt_drop <= r_drop;
            if (r_hdr_idx == HI_W'(HDR_WORDS - 1)) begin
              r_state <= ST_PAYLOAD;
              r_ch    <= '0;
              r_ent   <= '0;
              r_data  <= w_word_cur[0];
              r_eop   <= (SAMPLES_PER_PKT == 1) && (NUM_CH == 1);
            end else begin
              r_hdr_idx <= r_hdr_idx + HI_W'(1);
              r_data    <= w_hdr_next;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            if (r_eop) begin
              r_seq <= r_seq + 16'd1;
              r_eop <= 1'b0;
              if (w_restart) begin
                r_state   <= ST_HDR;
                r_sop     <= 1'b1;
                r_hdr_idx <= '0;
                r_data    <= DST_MAC[47:16];
              end else begin
                r_state <= ST_IDLE;
                r_wren  <= 1'b0;
                r_data  <= '0;
              end
            end else begin
              r_ch   <= w_ch_next;
              r_ent  <= w_ent_next;
              r_data <= w_pay_next;
              r_eop  <= w_eop_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Drop statistics; a drop coinciding with the w0 transfer carries into the next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_drop    <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_drop <= w_drop || (r_drop && !w_drop_clr);
      if (w_drop && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ff_tx_data    = r_data;
  assign ff_tx_wren    = r_wren;
  assign ff_tx_sop     = r_sop;
  assign ff_tx_eop     = r_eop;
  assign ff_tx_mod     = 2'b00;
  assign ff_tx_err     = 1'b0;
  assign ff_tx_crc_fwd = 1'b0;
  assign overflow_cnt  = r_ovf_cnt;
  assign fifo_level    = w_level;
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdr_tx_packetizer.sv
// Scoreboard bench for sdr_tx_packetizer (NUM_CH=2, SAMPLE_W=12, SAMPLES_PER_PKT=4, FIFO_DEPTH=256).
module tb_sdr_tx_packetizer;

  logic        clk = 1'b0;
  logic        rstn, enable, sample_valid, ff_tx_rdy;
  logic [23:0] sample_i, sample_q;
  logic [31:0] ff_tx_data;
  logic        ff_tx_wren, ff_tx_sop, ff_tx_eop, ff_tx_err, ff_tx_crc_fwd, busy;
  logic [1:0]  ff_tx_mod;
  logic [15:0] overflow_cnt;
  logic [8:0]  fifo_level;

  sdr_tx_packetizer #(
    .NUM_CH(2), .SAMPLE_W(12), .SAMPLES_PER_PKT(4), .FIFO_DEPTH(256)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .ff_tx_rdy(ff_tx_rdy),
    .ff_tx_data(ff_tx_data), .ff_tx_wren(ff_tx_wren), .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop), .ff_tx_mod(ff_tx_mod), .ff_tx_err(ff_tx_err),
    .ff_tx_crc_fwd(ff_tx_crc_fwd), .overflow_cnt(overflow_cnt),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] i0, q0, i1, q1;
    logic [31:0] w0, w1;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] pay_q [$];
  int          n_checks = 0, n_errors = 0;
  int          k = 0, frames_done = 0, cyc = 0, last_eop_cyc = 0, b2b_gap = -1;
  logic [15:0] m_seq = '0;
  bit          m_drop_pend = 0, m_frame_drop = 0, b2b_mode = 0, b2b_arm = 0, rdy_rand = 0;
  bit          hold_v = 0, hold_s = 0, hold_e = 0;
  logic [31:0] hold_d = '0, last_w3 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [11:0] i, input logic [11:0] q);
    return {{4{i[11]}}, i, {4{q[11]}}, q};
  endfunction

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_vec(input logic [11:0] i0, q0, i1, q1);
    sample_i = {i1, i0};
    sample_q = {q1, q0};
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic drive_rand(input int n, input bit accept);
    logic [11:0] a, b, c, d;
    for (int j = 0; j < n; j++) begin
      a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); d = 12'($urandom);
      if (accept) begin
        pay_q.push_back(exp_word(a, b));
        pay_q.push_back(exp_word(c, d));
      end
      drive_vec(a, b, c, d);
    end
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (frames_done < target) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout frames=%0d required=%0d", name, frames_done, target);
    end
  endtask

  task automatic wait_k(input int target, input int budget, input string name);
    int n = 0;
    while (k < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (k < target) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout word=%0d required=%0d", name, k, target);
    end
  endtask

  // Checks every transferred word against the model; also checks hold-while-stalled.
  task automatic monitor_loop();
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        k = 0;
        hold_v = 0;
      end else begin
        if (hold_v) begin
          chk("hold_data", ff_tx_data, hold_d);
          chk("hold_flags", {29'd0, ff_tx_wren, ff_tx_sop, ff_tx_eop}, {29'd0, 1'b1, hold_s, hold_e});
        end
        hold_v = ff_tx_wren && !ff_tx_rdy;
        hold_d = ff_tx_data; hold_s = ff_tx_sop; hold_e = ff_tx_eop;
        if (ff_tx_wren && ff_tx_rdy) begin
          if (k == 0) begin
            m_frame_drop = m_drop_pend;
            m_drop_pend = 0;
            if (b2b_arm) begin
              b2b_gap = cyc - last_eop_cyc;
              b2b_arm = 0;
            end
          end
          case (k)
            0: exp = 32'hFFFF_FFFF;
            1: exp = 32'hFFFF_0200;
            2: exp = 32'h0000_0001;
            3: exp = {16'h88B5, m_seq};
            4: exp = {8'h02, 7'h00, m_frame_drop, 16'h0004};
            default: begin
              if (pay_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL payload_underrun actual=%h required=none", ff_tx_data);
                exp = ff_tx_data;
              end else begin
                exp = pay_q.pop_front();
              end
            end
          endcase
          if (k == 3) last_w3 = ff_tx_data;
          chk($sformatf("tx_word%0d", k), ff_tx_data, exp);
          chk($sformatf("sop_word%0d", k), {31'd0, ff_tx_sop}, {31'd0, k == 0});
          chk($sformatf("eop_word%0d", k), {31'd0, ff_tx_eop}, {31'd0, k == 12});
          if (k == 12) begin
            k = 0;
            m_seq = m_seq + 16'd1;
            frames_done++;
            last_eop_cyc = cyc;
            if (b2b_mode) b2b_arm = 1;
          end else begin
            k++;
          end
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{12'h800, 12'h7FF, 12'h001, 12'hFFF, 32'hF800_07FF, 32'h0001_FFFF};
    tbl[1] = '{12'h123, 12'hABC, 12'h7FF, 12'h800, 32'h0123_FABC, 32'h07FF_F800};
    tbl[2] = '{12'h000, 12'h000, 12'hFFF, 12'h001, 32'h0000_0000, 32'hFFFF_0001};
    tbl[3] = '{12'h555, 12'hAAA, 12'h400, 12'hC00, 32'h0555_FAAA, 32'h0400_FC00};

    rstn = 1'b0; enable = 1'b0; sample_valid = 1'b0; ff_tx_rdy = 1'b0;
    sample_i = '0; sample_q = '0;

    fork
      monitor_loop();
      forever begin @(posedge clk); cyc++; end
      forever begin @(posedge clk); #1; if (rdy_rand) ff_tx_rdy = 1'($urandom_range(0, 1)); end
    join_none

    step(3);
    chk("rst_wren", {31'd0, ff_tx_wren}, 32'd0);
    chk("rst_data", ff_tx_data, 32'd0);
    chk("rst_sop_eop", {30'd0, ff_tx_sop, ff_tx_eop}, 32'd0);
    chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
    chk("rst_level", {23'd0, fifo_level}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    step(2);

    // Table-driven single frame with rdy held high.
    enable = 1'b1; ff_tx_rdy = 1'b1;
    foreach (tbl[j]) begin
      pay_q.push_back(tbl[j].w0);
      pay_q.push_back(tbl[j].w1);
      drive_vec(tbl[j].i0, tbl[j].q0, tbl[j].i1, tbl[j].q1);
    end
    wait_frames(1, 100, "frame_a");
    step(1);
    chk("a_level", {23'd0, fifo_level}, 32'd0);
    chk("a_busy", {31'd0, busy}, 32'd0);

    // Pseudo-random backpressure.
    rdy_rand = 1;
    drive_rand(4, 1);
    wait_frames(2, 400, "frame_b");
    rdy_rand = 0; ff_tx_rdy = 1'b1;
    step(2);

    // Overflow: stall w0, fill 256 entries, 3 strobes dropped.
    ff_tx_rdy = 1'b0;
    drive_rand(256, 1);
    drive_rand(3, 0);
    chk("c_ovf", {16'd0, overflow_cnt}, 32'd3);
    chk("c_level", {23'd0, fifo_level}, 32'd256);
    chk("c_busy", {31'd0, busy}, 32'd1);
    m_drop_pend = 1;
    ff_tx_rdy = 1'b1;
    wait_frames(66, 2000, "frame_c");
    step(2);
    chk("c_drained", {23'd0, fifo_level}, 32'd0);

    // Back-to-back frames with continuous input.
    b2b_mode = 1; b2b_gap = -1;
    drive_rand(8, 1);
    wait_frames(68, 200, "frame_d");
    b2b_mode = 0; b2b_arm = 0;
    chk("d_b2b_gap", 32'(b2b_gap), 32'd1);
    step(2);

    // Enable dropped mid-payload: frame completes, leftovers flushed.
    drive_rand(6, 1);
    wait_k(8, 100, "e_word8");
    enable = 1'b0;
    wait_frames(69, 100, "frame_e");
    step(2);
    chk("e_level", {23'd0, fifo_level}, 32'd0);
    chk("e_busy", {31'd0, busy}, 32'd0);
    chk("e_wren", {31'd0, ff_tx_wren}, 32'd0);
    chk("e_leftover", 32'(pay_q.size()), 32'd4);
    chk("e_ovf_kept", {16'd0, overflow_cnt}, 32'd3);
    pay_q.delete();

    // Reset pulsed mid-frame.
    enable = 1'b1;
    drive_rand(4, 1);
    wait_k(6, 100, "f_word6");
    rstn = 1'b0;
    #1;
    chk("f_wren", {31'd0, ff_tx_wren}, 32'd0);
    chk("f_busy", {31'd0, busy}, 32'd0);
    chk("f_level", {23'd0, fifo_level}, 32'd0);
    chk("f_ovf", {16'd0, overflow_cnt}, 32'd0);
    pay_q.delete();
    m_seq = '0; m_drop_pend = 0;
    step(2);
    rstn = 1'b1;
    step(1);
    drive_rand(4, 1);
    wait_frames(70, 100, "frame_f");
    chk("f_seq_after_reset", {16'd0, last_w3[15:0]}, 32'd0);
    chk("consts", {29'd0, ff_tx_mod, ff_tx_err ^ ff_tx_crc_fwd}, 32'd0);
    chk("crc_fwd", {31'd0, ff_tx_crc_fwd}, 32'd0);
    chk("payload_consumed", 32'(pay_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
